// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/stall handling and a saturating bubble counter.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      data1,
    input  logic [31:0]      data2,
    input  logic [31:0]      imm,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             regwrite,
    input  logic             memread,
    input  logic             memwrite,
    input  logic             memtoreg,
    input  logic             alusrc,
    input  logic             regdst,
    input  logic             uses_rt,
    input  logic [1:0]       aluop,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_data1,
    output logic [31:0]      ex_data2,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_wreg,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_alusrc,
    output logic [1:0]       ex_aluop,
    output logic             id_ready,
    output logic             hazard,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    ctrl_t ctrl_q;
    ctrl_t ctrl_in;

    // An empty decode slot is captured with all side-effecting controls cleared.
    assign ctrl_in = id_valid ? ctrl_t'{regwrite, memread, memwrite, memtoreg, alusrc, aluop}
                              : '0;

    assign hazard = id_valid & ex_valid & ctrl_q.memread & (ex_wreg != 5'd0) &
                    ((ex_wreg == rs) | (uses_rt & (ex_wreg == rt)));
    assign id_ready = ~ex_stall & ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here uses <= so all of them update from pre-edge values.
            ex_valid   <= 1'b0;
            ctrl_q     <= '0;
            ex_pc      <= '0;
            ex_data1   <= '0;
            ex_data2   <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ctrl_q   <= '0;
        end else if (ex_stall) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            ex_valid <= 1'b0;
            ctrl_q   <= '0;
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
        end else begin
            ex_valid <= id_valid;
            ctrl_q   <= ctrl_in;
            ex_pc    <= id_pc;
            ex_data1 <= data1;
            ex_data2 <= data2;
            ex_imm   <= imm;
            ex_rs    <= rs;
            ex_rt    <= rt;
            ex_wreg  <= regdst ? rd : rt;
        end
    end

    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_aluop    = ctrl_q.aluop;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 The block SHALL have port clk input 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-004 The block SHALL have port id_valid input 1, decode slot holds a real instruction.
REQ-005 The block SHALL have ports id_pc, data1, data2, imm, input 32 each: PC, register-file read data 1 and 2, sign-extended immediate.
REQ-006 The block SHALL have ports rs, rt, rd input 5 each, instruction register fields.
REQ-007 The block SHALL have control inputs regwrite, memread, memwrite, memtoreg, alusrc, regdst, uses_rt (1 each) and aluop (2).
REQ-008 The block SHALL have ports ex_stall input 1 (execute cannot accept) and flush input 1 (branch/jump kill).
REQ-009 The block SHALL have outputs ex_valid 1, ex_pc/ex_data1/ex_data2/ex_imm 32, ex_rs/ex_rt/ex_wreg 5, ex_regwrite/ex_memread/ex_memwrite/ex_memtoreg/ex_alusrc 1, ex_aluop 2.
REQ-010 The block SHALL have outputs id_ready 1 (decode may advance), hazard 1 (load-use detected), bubble_cnt CNT_W.

Function
REQ-011 hazard SHALL be combinational: id_valid & ex_valid & ex_memread & (ex_wreg != 0) & ((ex_wreg == rs) | (uses_rt & ex_wreg == rt)).
REQ-012 id_ready SHALL equal !ex_stall & !hazard, combinational.
REQ-013 Per rising edge, priority SHALL be flush > ex_stall > hazard > capture.
REQ-014 Flush: ex_valid <= 0 and all ex_ control bits (regwrite, memread, memwrite, memtoreg, alusrc, aluop) <= 0, regardless of ex_stall; datapath fields don't-care.
REQ-015 Stall (ex_stall=1, flush=0): every ex_ register SHALL hold its value.
REQ-016 Hazard (no flush, no stall): bubble inserted -- ex_valid <= 0, ex_ control bits <= 0, bubble_cnt increments.
REQ-017 Capture (none of the above): ex_valid <= id_valid; all ex_ fields <= corresponding inputs; ex_wreg <= regdst ? rd : rt.
REQ-018 On capture with id_valid=0, control bits SHALL be loaded as 0 so an invalid slot never writes registers or memory.
REQ-019 bubble_cnt SHALL saturate at all-ones and never wrap.
REQ-020 A hazard SHALL last exactly one cycle for a single load followed by a dependent instruction (after the bubble, ex_memread=0).
REQ-021 Simultaneous flush and hazard SHALL take the flush path; bubble_cnt SHALL NOT increment.
REQ-022 Simultaneous ex_stall and hazard SHALL hold; bubble_cnt SHALL NOT increment; hazard output remains asserted.
REQ-023 Register $zero (ex_wreg=0) SHALL never raise hazard.
REQ-024 Latency decode-to-execute SHALL be one cycle when unobstructed.

Reset
REQ-025 While rst_n=0, all ex_ outputs and bubble_cnt SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-stall or mid-bubble SHALL discard the in-flight instruction; first edge after release behaves as capture.
REQ-027 hazard and id_ready SHALL be evaluated from reset-state registers (hazard=0, id_ready=!ex_stall) during reset.

Verification
REQ-028 Reset: rst_n low async mid-cycle with ex_valid=1 -> all ex_ outputs 0 immediately, bubble_cnt=0.
REQ-029 Capture: id_valid=1, data1=4, data2=2, rt=10, rd=8, regdst=1, regwrite=1 -> next edge ex_valid=1, ex_data1=4, ex_data2=2, ex_wreg=8.
REQ-030 Load-use: lw into $8 in EX, decode rs=8 -> hazard=1, id_ready=0; next edge ex_valid=0, bubble_cnt=1; following edge dependent instruction captured.
REQ-031 Stall: ex_stall=1 for 3 cycles with changing inputs -> ex_ outputs unchanged; release -> next edge captures current inputs.
REQ-032 Flush vs hazard/stall: flush=1 with hazard=1 and ex_stall=1 -> ex_valid=0, control 0, bubble_cnt unchanged.
REQ-033 Saturation: CNT_W=2, force 5 load-use bubbles -> bubble_cnt reads 3 after the third and stays 3.
